// File: rtl/router_pkt_tx.sv
// Router packet source: buffers one payload, then sends header, payload and XOR parity.
// Latency: header is on data_out from the edge that loads the last payload byte; bytes then advance one per accept.
// Backpressure: a byte is taken on a rising edge with busy low; data_out and pkt_valid hold while busy is high.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] payload_len,
    output logic       cmd_ready,
    output logic       cmd_err,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       done,
    input  logic       abort
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      header_q, header_d;
    logic [7:0]      parity_q, parity_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            done_q, done_d;
    logic            cmd_err_q, cmd_err_d;
    logic [7:0]      buf_q [64];
    logic            buf_we;
    logic            last_byte;
    logic            accept;

    // header carries the length in its upper six bits
    assign last_byte = (cnt_q == (header_q[7:2] - 6'd1));
    assign accept    = !busy;

    always_comb begin
        state_d     = state_q;
        header_d    = header_q;
        parity_d    = parity_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        pkt_valid_d = pkt_valid_q;
        data_out_d  = data_out_q;
        done_d      = 1'b0;
        cmd_err_d   = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (payload_len == 6'd0 || dest_addr == 2'd3) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        header_d = {payload_len, dest_addr};
                        parity_d = {payload_len, dest_addr};
                        cnt_d    = 6'd0;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (pl_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ pl_data;
                    if (last_byte) begin
                        cnt_d       = 6'd0;
                        state_d     = S_HEADER;
                        pkt_valid_d = 1'b1;
                        data_out_d  = header_q;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_HEADER: begin
                if (accept) begin
                    state_d    = S_PAYLOAD;
                    data_out_d = buf_q[0];
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    if (last_byte) begin
                        state_d     = S_PARITY;
                        pkt_valid_d = 1'b0;
                        data_out_d  = parity_q;
                    end else begin
                        cnt_d      = cnt_q + 6'd1;
                        data_out_d = buf_q[cnt_q + 6'd1];
                    end
                end
            end
            S_PARITY: begin
                if (accept) begin
                    state_d = S_GAP;
                    done_d  = 1'b1;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort wins over any command or payload activity in the same cycle
        if (abort) begin
            state_d     = S_IDLE;
            pkt_valid_d = 1'b0;
            done_d      = 1'b0;
            cmd_err_d   = 1'b0;
            cnt_d       = 6'd0;
            buf_we      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            header_q    <= 8'h00;
            parity_q    <= 8'h00;
            cnt_q       <= 6'd0;
            gap_q       <= '0;
            pkt_valid_q <= 1'b0;
            data_out_q  <= 8'h00;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            header_q    <= header_d;
            parity_q    <= parity_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            pkt_valid_q <= pkt_valid_d;
            data_out_q  <= data_out_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // payload storage needs no reset; it is always written before being read
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buf_q[cnt_q] <= pl_data;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign pl_ready  = (state_q == S_LOAD);
    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_out_q;
    assign done      = done_q;
    assign cmd_err   = cmd_err_q;

endmodule
